// File: rtl/updn_counter_pkg.sv
// Shared encodings for the up/down modulo counter: boundary modes and FSM states.
// Constants only; no logic, no latency.
package updn_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/updn_next.sv
// Next-count and terminal-event logic for updn_mod_counter.
// Purely combinational, zero latency; no flow control.
module updn_next
    import updn_counter_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_en,
    input  logic             i_s,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_term
);

    logic w_at_max;
    logic w_at_zero;
    logic w_wrap;

    assign w_at_max  = (i_cnt == MAX);
    assign w_at_zero = (i_cnt == '0);
    // The reserved encoding behaves exactly like WRAP.
    assign w_wrap    = (i_mode == MODE_WRAP) || (i_mode == MODE_RSVD);
    assign o_term    = i_en & ((i_s & w_at_max) | (~i_s & w_at_zero));

    always_comb begin
        o_nxt = i_cnt;
        if (i_s) begin
            if (w_at_max) o_nxt = w_wrap ? '0 : MAX;
            else          o_nxt = i_cnt + WIDTH'(1);
        end else begin
            if (w_at_zero) o_nxt = w_wrap ? MAX : '0;
            else           o_nxt = i_cnt - WIDTH'(1);
        end
    end

endmodule

// File: rtl/updn_mod_counter.sv
// Loadable up/down modulo counter with wrap/saturate/one-shot modes and sticky overflow.
// cnt/ovf update one edge after inputs; Rc is combinational for cascading; no backpressure.
module updn_mod_counter
    import updn_counter_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             Rc,
    output logic             ovf,
    output logic             busy
);

    state_e           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_ld_val;
    logic             w_term;
    logic             w_run;

    updn_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_next (
        .i_cnt  (r_cnt),
        .i_en   (en),
        .i_s    (s),
        .i_mode (mode),
        .o_nxt  (w_nxt),
        .o_term (w_term)
    );

    assign w_run    = (r_state == ST_RUN);
    // Loads are clamped so the count can never leave 0..MAX.
    assign w_ld_val = (din > MAX) ? MAX : din;

    assign Rc   = w_term & ~ld & w_run;
    assign cnt  = r_cnt;
    assign ovf  = r_ovf;
    assign busy = w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            if (w_term)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;

            if (ld) begin
                r_cnt   <= w_ld_val;
                r_state <= ST_RUN;
            end else if (!w_run) begin
                if (mode != MODE_ONESHOT) r_state <= ST_RUN;
            end else if (en) begin
                r_cnt <= w_nxt;
                if (w_term && (mode == MODE_ONESHOT)) r_state <= ST_HALT;
            end
        end
    end

endmodule

// File: tb/tb_updn_mod_counter.sv
// Directed self-checking bench for updn_mod_counter (WIDTH=4/MAX=9, WIDTH=16 default, cascade).
module tb_updn_mod_counter;
    import updn_counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Main DUT, WIDTH=4 MAX=9
    logic       en = 0, s = 0, ld = 0, clr_ovf = 0;
    logic [3:0] din = '0;
    logic [1:0] mode = 2'b00;
    logic [3:0] cnt;
    logic       rc, ovf, busy;

    updn_mod_counter #(.WIDTH(4), .MAX(4'd9)) u_dut (
        .clk(clk), .rst(rst), .en(en), .s(s), .ld(ld), .din(din), .mode(mode),
        .clr_ovf(clr_ovf), .cnt(cnt), .Rc(rc), .ovf(ovf), .busy(busy)
    );

    // WIDTH=16 with default MAX
    logic        w_en = 0, w_s = 0;
    logic [15:0] w_din = '0;
    logic [1:0]  w_mode = 2'b00;
    logic [15:0] w_cnt;
    logic        w_rc, w_ovf, w_busy;

    updn_mod_counter #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .en(w_en), .s(w_s), .ld(1'b0), .din(w_din), .mode(w_mode),
        .clr_ovf(1'b0), .cnt(w_cnt), .Rc(w_rc), .ovf(w_ovf), .busy(w_busy)
    );

    // Cascade: low stage Rc drives high stage en
    logic       c_en = 0;
    logic [3:0] c_din = '0;
    logic [1:0] c_mode = 2'b00;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_rc, hi_rc, lo_ovf, hi_ovf, lo_busy, hi_busy;

    updn_mod_counter #(.WIDTH(4), .MAX(4'd9)) u_lo (
        .clk(clk), .rst(rst), .en(c_en), .s(1'b1), .ld(1'b0), .din(c_din), .mode(c_mode),
        .clr_ovf(1'b0), .cnt(lo_cnt), .Rc(lo_rc), .ovf(lo_ovf), .busy(lo_busy)
    );

    updn_mod_counter #(.WIDTH(4), .MAX(4'd9)) u_hi (
        .clk(clk), .rst(rst), .en(lo_rc), .s(1'b1), .ld(1'b0), .din(c_din), .mode(c_mode),
        .clr_ovf(1'b0), .cnt(hi_cnt), .Rc(hi_rc), .ovf(hi_ovf), .busy(hi_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return just after the following falling edge.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    int exp_sat [5] = '{2, 1, 0, 0, 0};

    initial begin
        #1;
        check("rst_cnt",  32'(cnt),  0);
        check("rst_ovf",  32'(ovf),  0);
        check("rst_busy", 32'(busy), 1);
        check("rst_rc",   32'(rc),   0);
        nxt();
        nxt();

        // Wrap up-count through MAX
        rst = 0; en = 1; s = 1; mode = MODE_WRAP;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("wrap_cnt", 32'(cnt), 32'(i % 10));
            check("wrap_rc",  32'(rc),  32'((i % 10) == 9));
            check("wrap_ovf", 32'(ovf), 32'(i >= 10));
            nxt();
        end

        // Load 2 then saturate down at 0
        en = 0; ld = 1; din = 4'd2;
        nxt();
        ld = 0; en = 1; s = 0; mode = MODE_SAT;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("sat_cnt", 32'(cnt), 32'(exp_sat[i]));
            check("sat_rc",  32'(rc),  32'(exp_sat[i] == 0));
            nxt();
        end
        check("sat_ovf", 32'(ovf), 1);
        en = 0; clr_ovf = 1;
        nxt();
        clr_ovf = 0;
        #1;
        check("clr_ovf", 32'(ovf), 0);

        // One-shot from 7 up to 9 then HALT
        mode = MODE_ONESHOT; ld = 1; din = 4'd7;
        nxt();
        ld = 0; en = 1; s = 1;
        #1;
        check("os_cnt7",  32'(cnt),  7);
        check("os_busy7", 32'(busy), 1);
        nxt();
        check("os_cnt8",  32'(cnt),  8);
        nxt();
        check("os_cnt9",  32'(cnt),  9);
        check("os_rc9",   32'(rc),   1);
        nxt();
        check("halt_cnt",  32'(cnt),  9);
        check("halt_busy", 32'(busy), 0);
        check("halt_rc",   32'(rc),   0);
        nxt();
        check("halt_cnt2", 32'(cnt),  9);
        check("halt_ovf",  32'(ovf),  1);
        ld = 1; din = 4'd3;
        #1;
        check("halt_ld_rc", 32'(rc), 0);
        nxt();
        ld = 0; en = 0;
        #1;
        check("reld_cnt",  32'(cnt),  3);
        check("reld_busy", 32'(busy), 1);

        // Clamped load; load beats enable
        mode = MODE_WRAP; ld = 1; din = 4'd15; en = 1; s = 1;
        nxt();
        check("clamp_cnt", 32'(cnt), 9);
        din = 4'd4;
        #1;
        check("ld_en_rc", 32'(rc), 0);
        nxt();
        check("ld_wins", 32'(cnt), 4);
        ld = 0; en = 0;
        nxt();
        check("hold_cnt", 32'(cnt), 4);

        // Asynchronous reset between edges at cnt=5
        en = 1; s = 1;
        nxt();
        en = 0;
        check("pre_rst_cnt", 32'(cnt), 5);
        #1 rst = 1;
        #1;
        check("arst_cnt",  32'(cnt),  0);
        check("arst_ovf",  32'(ovf),  0);
        check("arst_busy", 32'(busy), 1);
        nxt();
        rst = 0; s = 0; en = 1; clr_ovf = 1; mode = MODE_WRAP;
        #1;
        check("setclr_rc", 32'(rc), 1);
        nxt();
        clr_ovf = 0; en = 0;
        #1;
        check("setclr_ovf", 32'(ovf), 1);
        check("down_wrap",  32'(cnt), 9);

        // HALT left by changing mode
        mode = MODE_ONESHOT; s = 1; en = 1;
        #1;
        check("os2_rc", 32'(rc), 1);
        nxt();
        en = 0;
        #1;
        check("os2_busy", 32'(busy), 0);
        mode = MODE_WRAP;
        nxt();
        check("mexit_busy", 32'(busy), 1);
        check("mexit_cnt",  32'(cnt),  9);

        // WIDTH=16, default MAX, down from 0
        w_en = 1; w_s = 0;
        #1;
        check("w16_rc", 32'(w_rc), 1);
        nxt();
        w_en = 0;
        #1;
        check("w16_cnt", 32'(w_cnt), 32'hFFFF);

        // Cascade: high stage steps once per 10 low-stage counts
        c_en = 1;
        #1;
        for (int n = 1; n <= 25; n++) begin
            nxt();
            check("casc_lo", 32'(lo_cnt), 32'(n % 10));
            check("casc_hi", 32'(hi_cnt), 32'(n / 10));
        end
        c_en = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
